// File: rtl/spi_reg_bank_fifo.sv
// Register bank for the SPI controller: strobe-decoded registers, TX/RX frame FIFOs,
// start sequencing toward the shift engine and a maskable W1C interrupt.
module spi_reg_bank_fifo #(
  parameter int FRAME_W    = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_SS     = 4,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [31:0]        waddr,
  input  logic [31:0]        wdata,
  input  logic               wr_en,
  input  logic [31:0]        raddr,
  input  logic               rd_en,
  output logic [31:0]        rdata,
  output logic               wack,
  output logic               rack,
  output logic               waddrerr,
  output logic               raddrerr,
  output logic               ctrl_cpol,
  output logic               ctrl_cpha,
  output logic               ctrl_order,
  output logic               ctrl_rd,
  output logic [1:0]         ctrl_scks,
  output logic [NUM_SS-1:0]  ctrl_slave_en,
  output logic [FRAME_W-1:0] tx_data,
  output logic               tx_valid,
  input  logic               tx_pop,
  input  logic [FRAME_W-1:0] rx_data,
  input  logic               rx_push,
  input  logic               busy,
  input  logic               done,
  output logic               start_op,
  output logic               irq,
  output logic               start_state
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);
  localparam logic [31:0] CFG_MASK = 32'h0000_003F | (((32'h1 << NUM_SS) - 32'h1) << 8);
  localparam logic [31:0] A_TXDATA = 32'h00;
  localparam logic [31:0] A_RXDATA = 32'h04;
  localparam logic [31:0] A_CFG    = 32'h08;
  localparam logic [31:0] A_CTRL   = 32'h0C;
  localparam logic [31:0] A_STATUS = 32'h10;
  localparam logic [31:0] A_ISTAT  = 32'h14;
  localparam logic [31:0] A_IEN    = 32'h18;

  logic wr_ok, rd_ok;
  logic wr_tx, wr_cfg, wr_ctrl, wr_istat, wr_ien, rd_rx;
  logic start_wr, tx_flush, rx_flush;

  assign wr_ok    = (waddr[1:0] == 2'b00) && (waddr <= A_IEN);
  assign rd_ok    = (raddr[1:0] == 2'b00) && (raddr <= A_IEN);
  assign wr_tx    = wr_en && wr_ok && (waddr == A_TXDATA);
  assign wr_cfg   = wr_en && wr_ok && (waddr == A_CFG);
  assign wr_ctrl  = wr_en && wr_ok && (waddr == A_CTRL);
  assign wr_istat = wr_en && wr_ok && (waddr == A_ISTAT);
  assign wr_ien   = wr_en && wr_ok && (waddr == A_IEN);
  assign rd_rx    = rd_en && rd_ok && (raddr == A_RXDATA);
  assign start_wr = wr_ctrl && wdata[0];
  assign tx_flush = wr_ctrl && wdata[1];
  assign rx_flush = wr_ctrl && wdata[2];

  // TX FIFO: a push into a full FIFO still lands if the core pops in the same cycle.
  logic [FRAME_W-1:0] tx_mem [FIFO_DEPTH];
  logic [AW-1:0]      tx_wp, tx_rp;
  logic [LVL_W-1:0]   tx_level;
  logic tx_full, tx_empty, tx_do_pop, tx_do_push, tx_ovf;

  assign tx_full    = (tx_level == DEPTH_LVL);
  assign tx_empty   = (tx_level == '0);
  assign tx_do_pop  = tx_pop && !tx_empty;
  assign tx_do_push = wr_tx && (!tx_full || tx_do_pop);
  assign tx_ovf     = wr_tx && tx_full && !tx_do_pop && !tx_flush;
  assign tx_valid   = !tx_empty;
  assign tx_data    = tx_empty ? '0 : tx_mem[tx_rp];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_level <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) tx_mem[i] <= '0;
    end else if (tx_flush) begin
      tx_wp    <= '0;
      tx_rp    <= '0;
      tx_level <= '0;
    end else begin
      if (tx_do_push) begin
        tx_mem[tx_wp] <= wdata[FRAME_W-1:0];
        tx_wp         <= tx_wp + AW'(1);
      end
      if (tx_do_pop) tx_rp <= tx_rp + AW'(1);
      case ({tx_do_push, tx_do_pop})
        2'b10:   tx_level <= tx_level + LVL_W'(1);
        2'b01:   tx_level <= tx_level - LVL_W'(1);
        default: tx_level <= tx_level;
      endcase
    end
  end

  logic [FRAME_W-1:0] rx_mem [FIFO_DEPTH];
  logic [AW-1:0]      rx_wp, rx_rp;
  logic [LVL_W-1:0]   rx_level;
  logic rx_full, rx_empty, rx_do_pop, rx_do_push, rx_ovf, rx_udf;

  assign rx_full    = (rx_level == DEPTH_LVL);
  assign rx_empty   = (rx_level == '0);
  assign rx_do_pop  = rd_rx && !rx_empty;
  assign rx_do_push = rx_push && (!rx_full || rx_do_pop);
  assign rx_ovf     = rx_push && rx_full && !rx_do_pop && !rx_flush;
  assign rx_udf     = rd_rx && rx_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_level <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) rx_mem[i] <= '0;
    end else if (rx_flush) begin
      rx_wp    <= '0;
      rx_rp    <= '0;
      rx_level <= '0;
    end else begin
      if (rx_do_push) begin
        rx_mem[rx_wp] <= rx_data;
        rx_wp         <= rx_wp + AW'(1);
      end
      if (rx_do_pop) rx_rp <= rx_rp + AW'(1);
      case ({rx_do_push, rx_do_pop})
        2'b10:   rx_level <= rx_level + LVL_W'(1);
        2'b01:   rx_level <= rx_level - LVL_W'(1);
        default: rx_level <= rx_level;
      endcase
    end
  end

  // Start sequencing: a pending start waits for an idle core with data to send.
  typedef enum logic {S_IDLE = 1'b0, S_PEND = 1'b1} start_state_t;
  start_state_t state_q, state_d;
  logic fire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      start_op <= 1'b0;
    end else begin
      state_q  <= state_d;
      start_op <= fire;
    end
  end

  always_comb begin
    state_d = state_q;
    if (tx_flush) state_d = S_IDLE;
    else begin
      case (state_q)
        S_IDLE:  if (start_wr) state_d = S_PEND;
        S_PEND:  if (fire) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    fire = (state_q == S_PEND) && !busy && tx_valid && !tx_flush;
  end

  assign start_state = (state_q == S_PEND);

  logic [31:0] cfg_q;
  logic [3:0]  int_stat, int_en, int_set;

  assign int_set = {rx_udf, rx_ovf, tx_ovf, done};

  // Hardware set events are OR'd after the W1C mask so they cannot be lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cfg_q    <= '0;
      int_stat <= '0;
      int_en   <= '0;
    end else begin
      if (wr_cfg) cfg_q <= wdata & CFG_MASK;
      if (wr_ien) int_en <= wdata[3:0];
      int_stat <= (int_stat & ~(wr_istat ? wdata[3:0] : 4'h0)) | int_set;
    end
  end

  assign irq           = |(int_stat & int_en);
  assign ctrl_cpol     = cfg_q[0];
  assign ctrl_cpha     = cfg_q[1];
  assign ctrl_order    = cfg_q[2];
  assign ctrl_scks     = cfg_q[4:3];
  assign ctrl_rd       = cfg_q[5];
  assign ctrl_slave_en = cfg_q[8 +: NUM_SS];

  logic [31:0] status, rd_val;
  assign status = {8'h00, 8'(rx_level), 8'(tx_level), 3'b000,
                   rx_empty, rx_full, tx_empty, tx_full, busy};

  always_comb begin
    rd_val = '0;
    case (raddr)
      A_RXDATA: rd_val = rx_empty ? 32'h0 : 32'(rx_mem[rx_rp]);
      A_CFG:    rd_val = cfg_q;
      A_STATUS: rd_val = status;
      A_ISTAT:  rd_val = {28'h0, int_stat};
      A_IEN:    rd_val = {28'h0, int_en};
      default:  rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wack     <= 1'b0;
      rack     <= 1'b0;
      waddrerr <= 1'b0;
      raddrerr <= 1'b0;
      rdata    <= '0;
    end else begin
      wack     <= wr_en;
      rack     <= rd_en;
      waddrerr <= wr_en && !wr_ok;
      raddrerr <= rd_en && !rd_ok;
      if (rd_en) rdata <= rd_ok ? rd_val : 32'h0;
    end
  end
endmodule

// File: tb/tb_spi_reg_bank_fifo.sv
// Bench for spi_reg_bank_fifo: directed scenarios plus randomized FIFO traffic,
// checked against a queue-based register/FIFO model.
module tb_spi_reg_bank_fifo;
  localparam int FRAME_W    = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int NUM_SS     = 4;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic [31:0]        waddr = '0, wdata = '0, raddr = '0;
  logic               wr_en = 1'b0, rd_en = 1'b0;
  logic [31:0]        rdata;
  logic               wack, rack, waddrerr, raddrerr;
  logic               ctrl_cpol, ctrl_cpha, ctrl_order, ctrl_rd;
  logic [1:0]         ctrl_scks;
  logic [NUM_SS-1:0]  ctrl_slave_en;
  logic [FRAME_W-1:0] tx_data;
  logic               tx_valid;
  logic               tx_pop = 1'b0;
  logic [FRAME_W-1:0] rx_data = '0;
  logic               rx_push = 1'b0, busy = 1'b0, done = 1'b0;
  logic               start_op, irq, start_state;

  spi_reg_bank_fifo #(.FRAME_W(FRAME_W), .FIFO_DEPTH(FIFO_DEPTH), .NUM_SS(NUM_SS)) dut (
    .clk(clk), .reset(reset), .waddr(waddr), .wdata(wdata), .wr_en(wr_en),
    .raddr(raddr), .rd_en(rd_en), .rdata(rdata), .wack(wack), .rack(rack),
    .waddrerr(waddrerr), .raddrerr(raddrerr), .ctrl_cpol(ctrl_cpol), .ctrl_cpha(ctrl_cpha),
    .ctrl_order(ctrl_order), .ctrl_rd(ctrl_rd), .ctrl_scks(ctrl_scks),
    .ctrl_slave_en(ctrl_slave_en), .tx_data(tx_data), .tx_valid(tx_valid), .tx_pop(tx_pop),
    .rx_data(rx_data), .rx_push(rx_push), .busy(busy), .done(done), .start_op(start_op),
    .irq(irq), .start_state(start_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_cmp = 0, n_err = 0;
  int pulse_cnt = 0;
  always @(posedge clk) begin
    #2;
    if (start_op === 1'b1) pulse_cnt++;
  end

  // reference model
  logic [FRAME_W-1:0] tx_exp_q[$];
  logic [FRAME_W-1:0] rx_exp_q[$];
  logic [3:0]  m_stat = '0, m_en = '0;
  logic [31:0] m_cfg = '0;
  localparam logic [31:0] M_CFG_MASK = 32'h3F | (((32'h1 << NUM_SS) - 32'h1) << 8);

  function automatic logic addr_ok(input logic [31:0] a);
    return (a % 4 == 0) && (a <= 32'h18);
  endfunction

  function automatic logic [31:0] exp_status();
    int t = tx_exp_q.size();
    int r = rx_exp_q.size();
    return {8'h00, 8'(r), 8'(t), 3'b000, r == 0, r == FIFO_DEPTH, t == 0, t == FIFO_DEPTH, busy};
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] r = 32'h0;
    if (!addr_ok(a)) return 32'h0;
    case (a)
      32'h04: if (rx_exp_q.size() > 0) r = 32'(rx_exp_q.pop_front()); else m_stat[3] = 1'b1;
      32'h08: r = m_cfg;
      32'h10: r = exp_status();
      32'h14: r = {28'h0, m_stat};
      32'h18: r = {28'h0, m_en};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  function automatic void m_write(input logic [31:0] a, input logic [31:0] d);
    if (!addr_ok(a)) return;
    case (a)
      32'h00: if (tx_exp_q.size() < FIFO_DEPTH) tx_exp_q.push_back(d[FRAME_W-1:0]);
              else m_stat[1] = 1'b1;
      32'h08: m_cfg = d & M_CFG_MASK;
      32'h0C: begin
        if (d[1]) tx_exp_q.delete();
        if (d[2]) rx_exp_q.delete();
      end
      32'h14: m_stat = m_stat & ~d[3:0];
      32'h18: m_en = d[3:0];
      default: ;
    endcase
  endfunction

  // driver: one bus/core cycle, called at a negedge, samples at the next negedge
  logic        o_wack, o_werr, o_rack, o_rerr;
  logic [31:0] o_rdata, e_rdata;

  task automatic cycle_op(input logic do_wr, input logic [31:0] wa, input logic [31:0] wd,
                          input logic do_rd, input logic [31:0] ra,
                          input logic pop, input logic push, input logic [FRAME_W-1:0] rxd);
    logic rxf;
    wr_en = do_wr; waddr = wa; wdata = wd;
    rd_en = do_rd; raddr = ra;
    tx_pop = pop; rx_push = push; rx_data = rxd;
    e_rdata = do_rd ? m_read(ra) : 32'h0;
    if (pop && tx_exp_q.size() > 0) void'(tx_exp_q.pop_front());
    rxf = do_wr && (wa == 32'h0C) && wd[2];
    if (do_wr) m_write(wa, wd);
    if (push && !rxf) begin
      if (rx_exp_q.size() < FIFO_DEPTH) rx_exp_q.push_back(rxd);
      else m_stat[2] = 1'b1;
    end
    @(negedge clk);
    o_wack = wack; o_werr = waddrerr; o_rack = rack; o_rerr = raddrerr; o_rdata = rdata;
    wr_en = 1'b0; rd_en = 1'b0; tx_pop = 1'b0; rx_push = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    cycle_op(1'b1, a, d, 1'b0, 32'h0, 1'b0, 1'b0, '0);
  endtask

  task automatic rd(input logic [31:0] a);
    cycle_op(1'b0, 32'h0, 32'h0, 1'b1, a, 1'b0, 1'b0, '0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle_op(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, '0);
  endtask

  task automatic model_clear();
    tx_exp_q.delete(); rx_exp_q.delete();
    m_stat = '0; m_en = '0; m_cfg = '0;
  endtask

  task automatic test_reset();
    logic [59:0] outs;
    reset = 1'b0;
    #12;
    outs = {rdata, wack, rack, waddrerr, raddrerr, ctrl_cpol, ctrl_cpha, ctrl_order, ctrl_rd,
            ctrl_scks, ctrl_slave_en, tx_data, tx_valid, start_op, irq, start_state};
    n_cmp++;
    if (outs !== '0) begin n_err++; $display("FAIL reset_outputs: got %h want 0", outs); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    model_clear();
    rd(32'h10);
    n_cmp++;
    if (o_rdata !== 32'h0000_0014) begin n_err++; $display("FAIL reset_status: got %h want 00000014", o_rdata); end
    n_cmp++;
    if ({o_rack, o_rerr, irq} !== 3'b100) begin n_err++; $display("FAIL reset_rack_irq: got %b want 100", {o_rack, o_rerr, irq}); end
  endtask

  task automatic test_tx_fifo();
    logic [7:0] vals [5] = '{8'hA5, 8'h5A, 8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 5; i++) begin
      wr(32'h00, {24'h0, vals[i]});
      n_cmp++;
      if ({o_wack, o_werr} !== 2'b10) begin n_err++; $display("FAIL tx_push_ack[%0d]: got %b want 10", i, {o_wack, o_werr}); end
    end
    rd(32'h10);
    n_cmp++;
    if (o_rdata !== e_rdata) begin n_err++; $display("FAIL tx_full_status: got %h want %h", o_rdata, e_rdata); end
    rd(32'h14);
    n_cmp++;
    if (o_rdata !== 32'h2) begin n_err++; $display("FAIL tx_ovf_stat: got %h want 2", o_rdata); end
    n_cmp++;
    if ({tx_valid, tx_data} !== {1'b1, tx_exp_q[0]}) begin n_err++; $display("FAIL tx_head: got %b/%h want 1/%h", tx_valid, tx_data, tx_exp_q[0]); end
    wr(32'h18, 32'h2);
    n_cmp++;
    if (irq !== |(m_stat & m_en)) begin n_err++; $display("FAIL irq_enable: got %b want %b", irq, |(m_stat & m_en)); end
    wr(32'h14, 32'h2);
    n_cmp++;
    if (irq !== |(m_stat & m_en)) begin n_err++; $display("FAIL irq_w1c: got %b want %b", irq, |(m_stat & m_en)); end
  endtask

  task automatic test_cfg();
    wr(32'h08, 32'h0000_0F3F);
    n_cmp++;
    if ({ctrl_cpol, ctrl_cpha, ctrl_order, ctrl_rd, ctrl_scks, ctrl_slave_en} !== 10'b1111_11_1111) begin
      n_err++; $display("FAIL cfg_outputs: got %b want 1111111111",
                        {ctrl_cpol, ctrl_cpha, ctrl_order, ctrl_rd, ctrl_scks, ctrl_slave_en});
    end
    rd(32'h08);
    n_cmp++;
    if (o_rdata !== 32'h0000_0F3F) begin n_err++; $display("FAIL cfg_readback: got %h want 00000F3F", o_rdata); end
    wr(32'h08, 32'hFFFF_FFFF);
    rd(32'h08);
    n_cmp++;
    if (o_rdata !== e_rdata) begin n_err++; $display("FAIL cfg_unimpl_bits: got %h want %h", o_rdata, e_rdata); end
  endtask

  task automatic test_start();
    busy = 1'b1;
    wr(32'h0C, 32'h1);
    pulse_cnt = 0;
    idle(4);
    n_cmp++;
    if ({pulse_cnt != 0, start_state} !== 2'b01) begin n_err++; $display("FAIL start_busy_hold: pulses %0d pend %b want 0/1", pulse_cnt, start_state); end
    busy = 1'b0;
    idle(1);
    n_cmp++;
    if (start_op !== 1'b1) begin n_err++; $display("FAIL start_latency: got %b want 1", start_op); end
    idle(4);
    n_cmp++;
    if ({pulse_cnt == 1, start_state} !== 2'b10) begin n_err++; $display("FAIL start_single: pulses %0d pend %b want 1/0", pulse_cnt, start_state); end
    // second start while pending is absorbed into the first
    busy = 1'b1;
    wr(32'h0C, 32'h1);
    wr(32'h0C, 32'h1);
    pulse_cnt = 0;
    busy = 1'b0;
    idle(5);
    n_cmp++;
    if (pulse_cnt !== 1) begin n_err++; $display("FAIL start_absorb: pulses %0d want 1", pulse_cnt); end
    busy = 1'b1;
    wr(32'h0C, 32'h1);
    wr(32'h0C, 32'h2);
    n_cmp++;
    if (start_state !== 1'b0) begin n_err++; $display("FAIL flush_cancels_pend: got %b want 0", start_state); end
    pulse_cnt = 0;
    busy = 1'b0;
    wr(32'h00, 32'h77);
    idle(4);
    n_cmp++;
    if (pulse_cnt !== 0) begin n_err++; $display("FAIL flush_no_pulse: pulses %0d want 0", pulse_cnt); end
    wr(32'h0C, 32'h2);
    wr(32'h0C, 32'h1);
    pulse_cnt = 0;
    idle(4);
    n_cmp++;
    if (pulse_cnt !== 0) begin n_err++; $display("FAIL start_tx_empty: pulses %0d want 0", pulse_cnt); end
    wr(32'h00, 32'h66);
    idle(3);
    n_cmp++;
    if (pulse_cnt !== 1) begin n_err++; $display("FAIL start_after_push: pulses %0d want 1", pulse_cnt); end
  endtask

  task automatic test_done_irq();
    done = 1'b1; idle(1); done = 1'b0; m_stat[0] = 1'b1;
    rd(32'h14);
    n_cmp++;
    if (o_rdata !== e_rdata) begin n_err++; $display("FAIL done_sets: got %h want %h", o_rdata, e_rdata); end
    done = 1'b1; wr(32'h14, 32'h1); done = 1'b0; m_stat[0] = 1'b1;
    rd(32'h14);
    n_cmp++;
    if (o_rdata !== e_rdata) begin n_err++; $display("FAIL done_beats_w1c: got %h want %h", o_rdata, e_rdata); end
    wr(32'h14, 32'h1);
    rd(32'h14);
    n_cmp++;
    if (o_rdata !== e_rdata) begin n_err++; $display("FAIL done_w1c: got %h want %h", o_rdata, e_rdata); end
  endtask

  task automatic test_rx_fifo();
    cycle_op(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 8'hDE);
    cycle_op(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 8'hAD);
    for (int i = 0; i < 3; i++) begin
      rd(32'h04);
      n_cmp++;
      if (o_rdata !== e_rdata) begin n_err++; $display("FAIL rx_read[%0d]: got %h want %h", i, o_rdata, e_rdata); end
    end
    rd(32'h14);
    n_cmp++;
    if (o_rdata !== e_rdata || o_rdata[3] !== 1'b1) begin n_err++; $display("FAIL rx_udf: got %h want %h", o_rdata, e_rdata); end
    for (int i = 0; i < FIFO_DEPTH + 1; i++)
      cycle_op(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 8'(8'h40 + i));
    rd(32'h10);
    n_cmp++;
    if (o_rdata !== e_rdata) begin n_err++; $display("FAIL rx_full_status: got %h want %h", o_rdata, e_rdata); end
    cycle_op(1'b0, 32'h0, 32'h0, 1'b1, 32'h04, 1'b0, 1'b1, 8'h99);
    n_cmp++;
    if (o_rdata !== e_rdata) begin n_err++; $display("FAIL rx_pop_push_full: got %h want %h", o_rdata, e_rdata); end
    rd(32'h14);
    n_cmp++;
    if (o_rdata !== e_rdata) begin n_err++; $display("FAIL rx_ovf_stat: got %h want %h", o_rdata, e_rdata); end
  endtask

  task automatic test_addr_err();
    wr(32'h1C, 32'hFFFF);
    n_cmp++;
    if ({o_wack, o_werr} !== 2'b11) begin n_err++; $display("FAIL werr_1c: got %b want 11", {o_wack, o_werr}); end
    rd(32'h06);
    n_cmp++;
    if ({o_rack, o_rerr, o_rdata} !== {2'b11, 32'h0}) begin n_err++; $display("FAIL rerr_06: got %b %h want 11 0", {o_rack, o_rerr}, o_rdata); end
    wr(32'h02, 32'h99);
    wr(32'h0A, 32'h0);
    wr(32'h10, 32'hFFFF_FFFF);
    n_cmp++;
    if ({o_wack, o_werr} !== 2'b10) begin n_err++; $display("FAIL status_write_noerr: got %b want 10", {o_wack, o_werr}); end
    rd(32'h10);
    n_cmp++;
    if (o_rdata !== e_rdata) begin n_err++; $display("FAIL err_no_side_effect_status: got %h want %h", o_rdata, e_rdata); end
    rd(32'h08);
    n_cmp++;
    if (o_rdata !== e_rdata) begin n_err++; $display("FAIL err_no_side_effect_cfg: got %h want %h", o_rdata, e_rdata); end
    rd(32'h20);
    n_cmp++;
    if ({o_rack, o_rerr} !== 2'b11) begin n_err++; $display("FAIL rerr_20: got %b want 11", {o_rack, o_rerr}); end
  endtask

  task automatic test_back_to_back();
    wr(32'h0C, 32'h6);
    for (int i = 0; i < 3; i++) begin
      cycle_op(1'b1, 32'h00, 32'($urandom_range(255)), 1'b1, 32'h10, 1'b0, 1'b0, '0);
      n_cmp++;
      if ({o_wack, o_rack, o_werr, o_rerr} !== 4'b1100 || o_rdata !== e_rdata) begin
        n_err++; $display("FAIL b2b[%0d]: acks %b data %h want 1100 %h", i, {o_wack, o_rack, o_werr, o_rerr}, o_rdata, e_rdata);
      end
    end
  endtask

  task automatic test_random();
    logic        do_wr, do_rd, pop, push;
    logic [31:0] wa, wd, ra;
    for (int i = 0; i < 300; i++) begin
      do_wr = ($urandom_range(1) == 1);
      if ($urandom_range(15) == 0) begin
        wa = 32'h0C; wd = {29'h0, 2'($urandom_range(3)), 1'b0};
      end else begin
        wa = 32'h00; wd = $urandom;
      end
      do_rd = ($urandom_range(1) == 1);
      case ($urandom_range(3))
        0: ra = 32'h10;
        1: ra = 32'h14;
        default: ra = 32'h04;
      endcase
      pop  = ($urandom_range(2) == 0);
      push = ($urandom_range(1) == 1);
      cycle_op(do_wr, wa, wd, do_rd, ra, pop, push, 8'($urandom));
      n_cmp++;
      if (tx_valid !== (tx_exp_q.size() > 0) || tx_data !== (tx_exp_q.size() > 0 ? tx_exp_q[0] : 8'h0)) begin
        n_err++; $display("FAIL rand_tx_head[%0d]: got %b/%h want %0d entries", i, tx_valid, tx_data, tx_exp_q.size());
      end
      if (do_rd) begin
        n_cmp++;
        if (o_rdata !== e_rdata || o_rack !== 1'b1) begin
          n_err++; $display("FAIL rand_read[%0d] addr %h: got %h want %h", i, ra, o_rdata, e_rdata);
        end
      end
    end
    rd(32'h10);
    n_cmp++;
    if (o_rdata !== e_rdata) begin n_err++; $display("FAIL rand_final_status: got %h want %h", o_rdata, e_rdata); end
  endtask

  task automatic test_reset_midop();
    wr(32'h00, 32'h12);
    cycle_op(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1, 8'h34);
    wr(32'h08, 32'h3F);
    #2; reset = 1'b0;
    #1;
    n_cmp++;
    if ({tx_valid, ctrl_cpol, ctrl_scks, rdata, wack, start_op} !== '0) begin
      n_err++; $display("FAIL midop_reset: tx_valid %b cpol %b scks %b rdata %h", tx_valid, ctrl_cpol, ctrl_scks, rdata);
    end
    @(negedge clk); reset = 1'b1;
    model_clear();
    @(negedge clk);
    rd(32'h10);
    n_cmp++;
    if (o_rdata !== 32'h0000_0014) begin n_err++; $display("FAIL midop_status: got %h want 00000014", o_rdata); end
  endtask

  initial begin
    test_reset();
    test_tx_fifo();
    test_cfg();
    test_start();
    test_done_irq();
    test_rx_fifo();
    test_addr_err();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
